// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high-pulse widths of sig_in and queues them in a show-ahead FIFO.
// Define PULSE_COUNT_EN to add the pulse_count output (qualifying pulses seen, including dropped ones).
module pulse_width_meter #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_WIDTH  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_width,
  output logic             out_sat,
  output logic             overflow,
`ifdef PULSE_COUNT_EN
  output logic [15:0]      pulse_count,
`endif
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {WAIT_LOW, ARMED, MEASURE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [CNT_W:0] mem_q [FIFO_DEPTH];
  logic push_req, push, pop, full;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    push_req = 1'b0;
    case (state_q)
      WAIT_LOW: state_d = sig_in ? WAIT_LOW : ARMED;
      ARMED: if (sig_in) begin
        state_d = MEASURE;
        cnt_d   = CNT_W'(1);
        sat_d   = 1'b0;
      end
      MEASURE: if (sig_in) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        sat_d = sat_q | (&cnt_q);
      end else begin
        state_d  = ARMED;
        push_req = cnt_q >= MIN_W;
      end
      default: state_d = WAIT_LOW;
    endcase
  end
  assign out_valid  = count_q != '0;
  assign full       = count_q == DEPTH;
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts the new entry when the head leaves on the same edge.
  assign push       = push_req & (~full | pop);
  assign overflow_d = overflow_q | (push_req & full & ~pop);
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign out_width  = out_valid ? mem_q[rd_ptr_q][CNT_W-1:0] : '0;
  assign out_sat    = out_valid & mem_q[rd_ptr_q][CNT_W];
  assign overflow   = overflow_q;
  assign busy       = state_q == MEASURE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_LOW;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {sat_q, cnt_q};
  end
`ifdef PULSE_COUNT_EN
  logic [15:0] pulse_count_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pulse_count_q <= '0;
    else if (push_req) pulse_count_q <= pulse_count_q + 1'b1;
  end
  assign pulse_count = pulse_count_q;
`endif
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed checks of pulse_width_meter; dut_a uses CNT_W=4, dut_b uses MIN_WIDTH=2.
module tb_pulse_width_meter;
  logic clk = 1'b0, rst = 1'b1;
  logic sig_a = 1'b1, rdy_a = 1'b0, sig_b = 1'b0, rdy_b = 1'b0;
  logic val_a, sat_a, ovf_a, busy_a, val_b, sat_b, ovf_b, busy_b;
  logic [3:0] w_a;
  logic [7:0] w_b;
  int passed = 0, failed = 0;
  always #5 clk = ~clk;
`ifdef PULSE_COUNT_EN
  logic [15:0] pc_a, pc_b;
`endif
  pulse_width_meter #(.CNT_W(4), .FIFO_DEPTH(4), .MIN_WIDTH(1)) dut_a (
    .clock(clk), .reset(rst), .sig_in(sig_a), .out_ready(rdy_a), .out_valid(val_a),
    .out_width(w_a), .out_sat(sat_a), .overflow(ovf_a),
`ifdef PULSE_COUNT_EN
    .pulse_count(pc_a),
`endif
    .busy(busy_a));
  pulse_width_meter #(.CNT_W(8), .FIFO_DEPTH(4), .MIN_WIDTH(2)) dut_b (
    .clock(clk), .reset(rst), .sig_in(sig_b), .out_ready(rdy_b), .out_valid(val_b),
    .out_width(w_b), .out_sat(sat_b), .overflow(ovf_b),
`ifdef PULSE_COUNT_EN
    .pulse_count(pc_b),
`endif
    .busy(busy_b));
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask
  task automatic pulse_a(input int w);
    sig_a = 1'b1;
    step(w);
    sig_a = 1'b0;
    step();
  endtask
  initial begin
    step(2);
    chk("rst_valid", 32'(val_a), 0);
    chk("rst_width", 32'(w_a), 0);
    chk("rst_sat", 32'(sat_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    rst = 1'b0;
    step(5);
    chk("wait_low_busy", 32'(busy_a), 0);
    sig_a = 1'b0;
    step();
    chk("armed_empty", 32'(val_a), 0);
    rdy_a = 1'b1;
    sig_a = 1'b1;
    step(3);
    chk("p3_busy", 32'(busy_a), 1);
    chk("p3_not_yet", 32'(val_a), 0);
    sig_a = 1'b0;
    step();
    chk("p3_valid", 32'(val_a), 1);
    chk("p3_width", 32'(w_a), 3);
    chk("p3_sat", 32'(sat_a), 0);
    step();
    chk("p3_popped", 32'(val_a), 0);
    chk("p3_width_empty", 32'(w_a), 0);
    rdy_a = 1'b0;
    sig_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sat_busy", 32'(busy_a), 1);
    end
    sig_a = 1'b0;
    step();
    chk("sat_busy_after", 32'(busy_a), 0);
    chk("sat_valid", 32'(val_a), 1);
    chk("sat_width", 32'(w_a), 15);
    chk("sat_flag", 32'(sat_a), 1);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    chk("sat_popped", 32'(val_a), 0);
    for (int w = 1; w <= 5; w++) pulse_a(w);
    chk("full_ovf", 32'(ovf_a), 1);
    step(2);
    chk("hold_width", 32'(w_a), 1);
    chk("hold_sat", 32'(sat_a), 0);
    rdy_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_width", 32'(w_a), 32'(i));
      step();
    end
    chk("drain_empty", 32'(val_a), 0);
    chk("ovf_sticky", 32'(ovf_a), 1);
    rdy_a = 1'b0;
    rst = 1'b1;
    step();
    chk("midreset_ovf", 32'(ovf_a), 0);
    rst = 1'b0;
    step();
    for (int w = 1; w <= 4; w++) pulse_a(w);
    chk("refill_head", 32'(w_a), 1);
    sig_a = 1'b1;
    step(7);
    rdy_a = 1'b1;
    sig_a = 1'b0;
    step();
    chk("fullpop_ovf", 32'(ovf_a), 0);
    chk("fullpop_valid", 32'(val_a), 1);
    chk("fullpop_head", 32'(w_a), 2);
    chk("fifo_order0", 32'(w_a), 2);
    step();
    chk("fifo_order1", 32'(w_a), 3);
    step();
    chk("fifo_order2", 32'(w_a), 4);
    step();
    chk("fifo_order3", 32'(w_a), 7);
    step();
    chk("fullpop_empty", 32'(val_a), 0);
    rdy_a = 1'b0;
    sig_b = 1'b1;
    step();
    sig_b = 1'b0;
    step();
    chk("min_w1_dropped", 32'(val_b), 0);
    chk("min_w1_ovf", 32'(ovf_b), 0);
    sig_b = 1'b1;
    step(2);
    sig_b = 1'b0;
    step();
    chk("min_w2_valid", 32'(val_b), 1);
    chk("min_w2_width", 32'(w_b), 2);
    chk("min_w2_sat", 32'(sat_b), 0);
`ifdef PULSE_COUNT_EN
    chk("pulse_count_b", 32'(pc_b), 1);
    chk("pulse_count_a", 32'(pc_a), 5);
`endif
    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule
